// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: drives the handshaked data-memory port,
// formats big-endian load data and registers the MEM/WB fields.
module mem_access_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_signed,
    input  logic        ex_reg_write,
    input  logic        ex_memtoreg,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_write_data,
    input  logic [4:0]  ex_reg_dst,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        wb_reg_write,
    output logic        wb_memtoreg,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_reg_dst,
    output logic [31:0] wb_mem_read_data,
    output logic        stall,
    output logic        addr_exc,
    output logic        bus_err
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_waitCnt;

    logic               w_memOp;
    logic               w_misaligned;
    logic               w_startAccess;
    logic               w_done;
    logic               w_timeout;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [7:0]         w_laneByte;
    logic [15:0]        w_laneHalf;
    logic [31:0]        w_loadData;

    logic [31:0]        r_addr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic               r_we;
    logic               r_read;
    logic [1:0]         r_size;
    logic               r_signed;
    logic [1:0]         r_off;
    logic               r_regWrite;
    logic               r_memtoreg;
    logic [31:0]        r_aluResult;
    logic [4:0]         r_regDst;

    logic               r_wbRegWrite;
    logic               r_wbMemtoreg;
    logic [31:0]        r_wbAluResult;
    logic [4:0]         r_wbRegDst;
    logic [31:0]        r_wbMemData;

    assign w_memOp       = ex_mem_read | ex_mem_write;
    assign w_misaligned  = ((ex_mem_size == 2'b01) & ex_alu_result[0])
                         | (ex_mem_size[1] & (|ex_alu_result[1:0]));
    assign w_startAccess = (r_state == IDLE) & w_memOp & ~w_misaligned;
    assign w_done        = (r_state == ACCESS) & dm_ack;
    assign w_timeout     = (r_state == ACCESS) & ~dm_ack & (r_waitCnt == CNT_W'(MAX_WAIT - 1));

    // Lane steering: byte 0 of a word lives in bits [31:24].
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = ex_write_data;
        case (ex_mem_size)
            2'b00: begin
                w_be    = 4'b1000 >> ex_alu_result[1:0];
                w_wdata = {4{ex_write_data[7:0]}};
            end
            2'b01: begin
                w_be    = ex_alu_result[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{ex_write_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_laneByte = dm_rdata[31:24];
        case (r_off)
            2'd1:    w_laneByte = dm_rdata[23:16];
            2'd2:    w_laneByte = dm_rdata[15:8];
            2'd3:    w_laneByte = dm_rdata[7:0];
            default: ;
        endcase
        w_laneHalf = r_off[1] ? dm_rdata[15:0] : dm_rdata[31:16];
        w_loadData = dm_rdata;
        case (r_size)
            2'b00:   w_loadData = {{24{r_signed & w_laneByte[7]}}, w_laneByte};
            2'b01:   w_loadData = {{16{r_signed & w_laneHalf[15]}}, w_laneHalf};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_waitCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= (r_state == ACCESS && w_nextState == ACCESS) ? r_waitCnt + CNT_W'(1) : '0;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_startAccess) w_nextState = ACCESS;
            ACCESS:  if (w_done || w_timeout) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Stall stays high through the ack cycle so the next op is sampled only in IDLE.
    always_comb begin
        dm_req   = (r_state == ACCESS);
        stall    = w_startAccess | (r_state == ACCESS);
        addr_exc = (r_state == IDLE) & w_memOp & w_misaligned;
        bus_err  = w_timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr        <= '0;
            r_be          <= '0;
            r_wdata       <= '0;
            r_we          <= 1'b0;
            r_read        <= 1'b0;
            r_size        <= '0;
            r_signed      <= 1'b0;
            r_off         <= '0;
            r_regWrite    <= 1'b0;
            r_memtoreg    <= 1'b0;
            r_aluResult   <= '0;
            r_regDst      <= '0;
            r_wbRegWrite  <= 1'b0;
            r_wbMemtoreg  <= 1'b0;
            r_wbAluResult <= '0;
            r_wbRegDst    <= '0;
            r_wbMemData   <= '0;
        end else begin
            if (w_startAccess) begin
                r_addr      <= {ex_alu_result[31:2], 2'b00};
                r_be        <= w_be;
                r_wdata     <= w_wdata;
                r_we        <= ex_mem_write;
                r_read      <= ex_mem_read;
                r_size      <= ex_mem_size;
                r_signed    <= ex_mem_signed;
                r_off       <= ex_alu_result[1:0];
                r_regWrite  <= ex_reg_write;
                r_memtoreg  <= ex_memtoreg;
                r_aluResult <= ex_alu_result;
                r_regDst    <= ex_reg_dst;
            end
            r_wbRegWrite  <= 1'b0;
            r_wbMemtoreg  <= 1'b0;
            r_wbAluResult <= '0;
            r_wbRegDst    <= '0;
            r_wbMemData   <= '0;
            if (r_state == IDLE && !w_memOp) begin
                r_wbRegWrite  <= ex_reg_write;
                r_wbMemtoreg  <= ex_memtoreg;
                r_wbAluResult <= ex_alu_result;
                r_wbRegDst    <= ex_reg_dst;
            end else if (w_done) begin
                r_wbRegWrite  <= r_regWrite;
                r_wbMemtoreg  <= r_memtoreg;
                r_wbAluResult <= r_aluResult;
                r_wbRegDst    <= r_regDst;
                r_wbMemData   <= r_read ? w_loadData : 32'h0;
            end
        end
    end

    assign dm_we            = r_we;
    assign dm_addr          = r_addr;
    assign dm_be            = r_be;
    assign dm_wdata         = r_wdata;
    assign wb_reg_write     = r_wbRegWrite;
    assign wb_memtoreg      = r_wbMemtoreg;
    assign wb_alu_result    = r_wbAluResult;
    assign wb_reg_dst       = r_wbRegDst;
    assign wb_mem_read_data = r_wbMemData;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected MEM/WB results are queued when an
// op is driven and popped when the stage writes them back.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_read, ex_mem_write, ex_mem_signed, ex_reg_write, ex_memtoreg;
    logic [1:0]  ex_mem_size;
    logic [31:0] ex_alu_result, ex_write_data;
    logic [4:0]  ex_reg_dst;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        wb_reg_write, wb_memtoreg;
    logic [31:0] wb_alu_result, wb_mem_read_data;
    logic [4:0]  wb_reg_dst;
    logic        stall, addr_exc, bus_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic [31:0] alu;
        logic [4:0]  dst;
        logic [31:0] data;
    } wb_t;

    wb_t expQ[$];

    mem_access_stage #(.MAX_WAIT(16)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_size(ex_mem_size), .ex_mem_signed(ex_mem_signed),
        .ex_reg_write(ex_reg_write), .ex_memtoreg(ex_memtoreg),
        .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
        .ex_reg_dst(ex_reg_dst),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .wb_reg_write(wb_reg_write), .wb_memtoreg(wb_memtoreg),
        .wb_alu_result(wb_alu_result), .wb_reg_dst(wb_reg_dst),
        .wb_mem_read_data(wb_mem_read_data),
        .stall(stall), .addr_exc(addr_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Reference load formatter: select the big-endian lane by shifting, then extend.
    function automatic logic [31:0] fmtLoad(input logic [1:0] size, input logic sgn,
                                            input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] sh;
        if (size == 2'b00) begin
            sh = rd >> (8 * (3 - int'(off)));
            return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
        end else if (size == 2'b01) begin
            sh = rd >> (16 * (1 - int'(off[1])));
            return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
        end
        return rd;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] size,
                                 input logic sgn, input logic rw, input logic mtr,
                                 input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [4:0] dst);
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_mem_size   = size;
        ex_mem_signed = sgn;
        ex_reg_write  = rw;
        ex_memtoreg   = mtr;
        ex_alu_result = alu;
        ex_write_data = wd;
        ex_reg_dst    = dst;
    endtask

    task automatic applyNop;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic expectWb(input logic rw, input logic mtr, input logic [31:0] alu,
                            input logic [4:0] dst, input logic [31:0] data);
        wb_t e;
        e.rw = rw; e.mtr = mtr; e.alu = alu; e.dst = dst; e.data = data;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkWb(input string tag);
        wb_t e;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s scoreboard empty observed=0x%08h expected=entry", tag, wb_alu_result);
            return;
        end
        e = expQ.pop_front();
        checkOutput({tag, ".reg_write"}, 32'(wb_reg_write), 32'(e.rw));
        checkOutput({tag, ".memtoreg"},  32'(wb_memtoreg),  32'(e.mtr));
        checkOutput({tag, ".alu"},       wb_alu_result,     e.alu);
        checkOutput({tag, ".dst"},       32'(wb_reg_dst),   32'(e.dst));
        checkOutput({tag, ".data"},      wb_mem_read_data,  e.data);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stallCycles;
        rst = 1'b1;
        dm_ack = 1'b0;
        dm_rdata = 32'h0;
        applyNop();
        tick();
        tick();
        sample();
        checkOutput("reset.dm_req", 32'(dm_req), 32'd0);
        checkOutput("reset.stall", 32'(stall), 32'd0);
        checkOutput("reset.dm_be", 32'(dm_be), 32'd0);
        expectWb(1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        checkWb("reset.wb");

        // 1: ALU op passes through with one cycle of latency
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 32'h1234, 32'h0, 5'd5);
        expectWb(1'b1, 1'b0, 32'h1234, 5'd5, 32'h0);
        sample();
        checkOutput("add.stall", 32'(stall), 32'd0);
        tick();
        applyNop();
        sample();
        checkWb("add.wb");

        // 2: lb signed at offset 1, ack in second ACCESS cycle
        stallCycles = 0;
        tick();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 32'h101, 32'h0, 5'd9);
        expectWb(1'b1, 1'b1, 32'h101, 5'd9, fmtLoad(2'b00, 1'b1, 2'd1, 32'h11F2_3344));
        sample();
        if (stall) stallCycles++;
        checkOutput("lb.req_n", 32'(dm_req), 32'd0);
        tick();
        sample();
        if (stall) stallCycles++;
        checkOutput("lb.req", 32'(dm_req), 32'd1);
        checkOutput("lb.be", 32'(dm_be), 32'b0100);
        checkOutput("lb.addr", dm_addr, 32'h100);
        checkOutput("lb.we", 32'(dm_we), 32'd0);
        checkOutput("lb.wb_bubble", 32'(wb_reg_write), 32'd0);
        tick();
        dm_ack = 1'b1;
        dm_rdata = 32'h11F2_3344;
        sample();
        if (stall) stallCycles++;
        tick();
        dm_ack = 1'b0;
        applyNop();
        sample();
        if (stall) stallCycles++;
        checkOutput("lb.stall_cycles", 32'(stallCycles), 32'd3);
        checkOutput("lb.req_done", 32'(dm_req), 32'd0);
        checkWb("lb.wb");

        // 3: sh at offset 2, best-case ack
        tick();
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 32'h202, 32'h0000_ABCD, 5'd0);
        expectWb(1'b0, 1'b0, 32'h202, 5'd0, 32'h0);
        sample();
        checkOutput("sh.stall", 32'(stall), 32'd1);
        tick();
        dm_ack = 1'b1;
        sample();
        checkOutput("sh.req", 32'(dm_req), 32'd1);
        checkOutput("sh.we", 32'(dm_we), 32'd1);
        checkOutput("sh.be", 32'(dm_be), 32'b0011);
        checkOutput("sh.wdata", dm_wdata, 32'hABCD_ABCD);
        checkOutput("sh.addr", dm_addr, 32'h200);
        tick();
        dm_ack = 1'b0;
        applyNop();
        sample();
        checkOutput("sh.stall_done", 32'(stall), 32'd0);
        checkWb("sh.wb");

        // 4: misaligned lw is dropped
        tick();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 32'h103, 32'h0, 5'd3);
        sample();
        checkOutput("lwmis.addr_exc", 32'(addr_exc), 32'd1);
        checkOutput("lwmis.stall", 32'(stall), 32'd0);
        checkOutput("lwmis.req", 32'(dm_req), 32'd0);
        tick();
        applyNop();
        expectWb(1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        sample();
        checkOutput("lwmis.addr_exc_end", 32'(addr_exc), 32'd0);
        checkOutput("lwmis.req_after", 32'(dm_req), 32'd0);
        checkWb("lwmis.wb");

        // 5: lw with no ack times out on the 16th ACCESS cycle
        tick();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd7);
        sample();
        for (int k = 1; k <= 16; k++) begin
            tick();
            sample();
            checkOutput($sformatf("lwto.req_bus_err_c%0d", k), 32'({dm_req, bus_err}),
                        32'({1'b1, (k == 16)}));
        end
        tick();
        applyNop();
        expectWb(1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        sample();
        checkOutput("lwto.req_drop", 32'(dm_req), 32'd0);
        checkOutput("lwto.bus_err_end", 32'(bus_err), 32'd0);
        checkOutput("lwto.stall", 32'(stall), 32'd0);
        checkWb("lwto.wb");

        // 6: reset in the second ACCESS cycle, late ack ignored
        tick();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd4);
        sample();
        tick();
        sample();
        checkOutput("rstacc.req1", 32'(dm_req), 32'd1);
        tick();
        rst = 1'b1;
        sample();
        tick();
        rst = 1'b0;
        applyNop();
        dm_ack = 1'b1;
        dm_rdata = 32'hDEAD_BEEF;
        expectWb(1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        sample();
        checkOutput("rstacc.req", 32'(dm_req), 32'd0);
        checkOutput("rstacc.stall", 32'(stall), 32'd0);
        checkWb("rstacc.wb");
        tick();
        dm_ack = 1'b0;
        expectWb(1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        sample();
        checkWb("rstacc.wb_after");

        // 7: lh signed at offset 2, best-case ack
        tick();
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 32'h502, 32'h0, 5'd12);
        expectWb(1'b1, 1'b1, 32'h502, 5'd12, fmtLoad(2'b01, 1'b1, 2'd2, 32'h1234_8765));
        sample();
        tick();
        dm_ack = 1'b1;
        dm_rdata = 32'h1234_8765;
        sample();
        checkOutput("lh.be", 32'(dm_be), 32'b0011);
        tick();
        dm_ack = 1'b0;
        applyNop();
        sample();
        checkWb("lh.wb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
